instruction_fetch: RTL

- IF stage, directly upstream of the 8-bit instruction splitter.
- Holds the PC and a loadable instruction memory, and presents one 8-bit instruction per cycle through an IF/ID pipeline register.
- Supports stall, flush, branch redirect and a halt state.

---
 rtl/instruction_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// IF stage: PC, loadable instruction memory and IF/ID register, with halt FSM.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
  parameter int PC_WIDTH = 8,
  parameter int INST_WIDTH = 8,
  parameter logic [INST_WIDTH-1:0] HALT_INST = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  imem_we,
  input  logic [PC_WIDTH-1:0]   imem_waddr,
  input  logic [INST_WIDTH-1:0] imem_wdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic [15:0]           perf_fetched,
  output logic [15:0]           perf_stalls
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state, state_n;

  logic [INST_WIDTH-1:0] mem [0:(1<<PC_WIDTH)-1];
  logic [INST_WIDTH-1:0] fetch;
  logic [PC_WIDTH-1:0]   pc_n, ipc_n, pc_inc;
  logic [INST_WIDTH-1:0] inst_n;
  logic                  v_n;

  // Async read: a same-cycle write lands after the fetch samples old data.
  assign fetch  = mem[pc];
  assign pc_inc = pc + PC_WIDTH'(1);
  assign halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    state      <= state_n;
    pc         <= pc_n;
    inst       <= inst_n;
    inst_pc    <= ipc_n;
    inst_valid <= v_n;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst;
    ipc_n   = inst_pc;
    v_n     = inst_valid;
    if (rst) begin
      state_n = RUN;
      pc_n    = '0;
      inst_n  = '0;
      ipc_n   = '0;
      v_n     = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            pc_n   = branch_target;
            inst_n = '0;
            v_n    = 1'b0;
          end else if (stall) begin
            if (flush) begin
              inst_n = '0;
              v_n    = 1'b0;
            end
          end else if (flush) begin
            inst_n = '0;
            v_n    = 1'b0;
            pc_n   = pc_inc;
          end else begin
            inst_n = fetch;
            ipc_n  = pc;
            v_n    = 1'b1;
            if (fetch == HALT_INST) state_n = HALTED;
            else pc_n = pc_inc;
          end
        end
        HALTED: begin
          v_n = 1'b0;
          if (flush) inst_n = '0;
          if (branch_taken) begin
            pc_n    = branch_target;
            inst_n  = '0;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic run_now, fetch_evt, stall_evt;

  assign run_now   = !rst && (state == RUN) && !branch_taken;
  assign fetch_evt = run_now && !stall && !flush;
  assign stall_evt = run_now && stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (fetch_evt && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (stall_evt && perf_stalls != 16'hFFFF)
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`else
  assign perf_fetched = 16'h0000;
  assign perf_stalls  = 16'h0000;
`endif

endmodule
